// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for demux_1to2_stream.
//   DEFAULT_WIDTH      default data width
//   DEFAULT_CNT_WIDTH  default transfer-counter width
//   SEL_A / SEL_B      in_sel encodings
//   slot_state_t       per-output holding register state
package demux_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_CNT_WIDTH = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// demux_out_slot: single-entry output holding register with valid/ready.
// Optional drain counter when DEMUX_XFER_CNT_EN is defined.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         capture load_data this edge (caller guarantees slot_ready)
//   load_data    beat to capture
//   slot_ready   slot can take a beat this cycle (~valid | ready)
//   data, valid  output beat and its valid flag
//   ready        downstream consumer accepts
//   cnt          completed drains (DEMUX_XFER_CNT_EN only)
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int width     = DEFAULT_WIDTH
`ifdef DEMUX_XFER_CNT_EN
   ,parameter int cnt_width = DEFAULT_CNT_WIDTH
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [width-1:0]     load_data,
    output logic                 slot_ready,
    output logic [width-1:0]     data,
    output logic                 valid,
    input  logic                 ready
`ifdef DEMUX_XFER_CNT_EN
   ,output logic [cnt_width-1:0] cnt
`endif
);

    slot_state_t state, state_nxt;
    logic        drain;

    assign valid      = (state == SLOT_FULL);
    assign drain      = valid & ready;
    assign slot_ready = ~valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SLOT_EMPTY;
        else        state <= state_nxt;
    end

    // Load wins over drain: a simultaneous drain+load stays FULL with the new beat.
    always_comb begin
        state_nxt = state;
        if (load)       state_nxt = SLOT_FULL;
        else if (drain) state_nxt = SLOT_EMPTY;
    end

    // Data is only written on load; after a drain the old value stays visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    data <= '0;
        else if (load) data <= load_data;
    end

`ifdef DEMUX_XFER_CNT_EN
    // Free-running wrap at 2^cnt_width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cnt <= '0;
        else if (drain) cnt <= cnt + 1'b1;
    end
`endif

endmodule

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: registered 1-to-2 valid/ready stream demultiplexer.
// One cycle latency, full throughput per output, independent backpressure.
// Optional macro: DEMUX_XFER_CNT_EN adds cnt_a/cnt_b drain counters.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake (in_ready independent of in_valid)
//   in_data, in_sel       input beat and route (0 -> a, 1 -> b)
//   a, a_valid, a_ready   output a stream
//   b, b_valid, b_ready   output b stream
//   cnt_a, cnt_b          completed transfers per output (DEMUX_XFER_CNT_EN only)
module demux_1to2_stream
    import demux_pkg::*;
#(
    parameter int width     = DEFAULT_WIDTH,
    parameter int cnt_width = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_data,
    input  logic                 in_sel,
    output logic [width-1:0]     a,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [width-1:0]     b,
    output logic                 b_valid,
    input  logic                 b_ready
`ifdef DEMUX_XFER_CNT_EN
   ,output logic [cnt_width-1:0] cnt_a
   ,output logic [cnt_width-1:0] cnt_b
`endif
);

    localparam int NUM_OUT = 2;

    logic [NUM_OUT-1:0]            load;
    logic [NUM_OUT-1:0]            slot_rdy;
    logic [NUM_OUT-1:0]            vld;
    logic [NUM_OUT-1:0]            rdy;
    logic [NUM_OUT-1:0][width-1:0] dout;
`ifdef DEMUX_XFER_CNT_EN
    logic [NUM_OUT-1:0][cnt_width-1:0] cnt;
`else
    // Without the counter build cnt_width has no hardware; the empty block
    // only keeps the parameter referenced for lint.
    if (cnt_width < 1) begin : g_cnt_width_unused
    end
`endif

    assign rdy = {b_ready, a_ready};

    // Only the selected slot's readiness gates the input; the other
    // output's backpressure never blocks this beat.
    assign in_ready = (in_sel == SEL_B) ? slot_rdy[1] : slot_rdy[0];

    assign load[0] = in_valid & in_ready & (in_sel == SEL_A);
    assign load[1] = in_valid & in_ready & (in_sel == SEL_B);

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
        demux_out_slot #(
            .width     (width)
`ifdef DEMUX_XFER_CNT_EN
           ,.cnt_width (cnt_width)
`endif
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[g]),
            .load_data  (in_data),
            .slot_ready (slot_rdy[g]),
            .data       (dout[g]),
            .valid      (vld[g]),
            .ready      (rdy[g])
`ifdef DEMUX_XFER_CNT_EN
           ,.cnt        (cnt[g])
`endif
        );
    end

    assign a       = dout[0];
    assign a_valid = vld[0];
    assign b       = dout[1];
    assign b_valid = vld[1];

`ifdef DEMUX_XFER_CNT_EN
    assign cnt_a = cnt[0];
    assign cnt_b = cnt[1];
`endif

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Testbench for demux_1to2_stream (width=8; cnt_width=4 in the counter build).
module tb_demux_1to2_stream;

    localparam int W  = 8;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_sel, a_ready, b_ready;
    logic         in_ready, a_valid, b_valid;
    logic [W-1:0] in_data, a, b;
`ifdef DEMUX_XFER_CNT_EN
    logic [CW-1:0] cnt_a, cnt_b;
`endif

    demux_1to2_stream #(.width(W), .cnt_width(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .a        (a),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b        (b),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_XFER_CNT_EN
       ,.cnt_a    (cnt_a)
       ,.cnt_b    (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           exp_cnt_a = 0;
    int           exp_cnt_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard, sampled mid-cycle: drains pop the older beat first, then
    // any accepted beat is pushed for the selected output.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete(); qb.delete();
            exp_cnt_a = 0; exp_cnt_b = 0;
        end else begin
            if (a_valid && a_ready) begin
                if (qa.size() == 0) check("sb_a_unexpected", {24'd0, a}, 32'hFFFF_FFFF);
                else check("sb_a_data", {24'd0, a}, {24'd0, qa.pop_front()});
                exp_cnt_a = exp_cnt_a + 1;
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) check("sb_b_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
                else check("sb_b_data", {24'd0, b}, {24'd0, qb.pop_front()});
                exp_cnt_b = exp_cnt_b + 1;
            end
            if (in_valid && in_ready) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [W-1:0] d);
        in_valid = v; in_sel = s; in_data = d;
    endtask

    initial begin
        logic hold;
        logic acc;
        rst_n = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        drive(1'b0, 1'b0, '0);

        // reset and idle
        step(); step();
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_a_valid", {31'd0, a_valid}, 32'd0);
        check("idle_b_valid", {31'd0, b_valid}, 32'd0);
        check("idle_a", {24'd0, a}, 32'h00);
        check("idle_b", {24'd0, b}, 32'h00);
`ifdef DEMUX_XFER_CNT_EN
        check("idle_cnt_a", {28'd0, cnt_a}, 32'd0);
        check("idle_cnt_b", {28'd0, cnt_b}, 32'd0);
`endif

        // basic routing
        drive(1'b1, 1'b0, 8'hA0);
        #1 check("basic_rdy0", {31'd0, in_ready}, 32'd1);
        step();
        check("basic_a", {24'd0, a}, 32'hA0);
        check("basic_a_valid", {31'd0, a_valid}, 32'd1);
        drive(1'b1, 1'b1, 8'hB0);
        #1 check("basic_rdy1", {31'd0, in_ready}, 32'd1);
        step();
        check("basic_b", {24'd0, b}, 32'hB0);
        check("basic_b_valid", {31'd0, b_valid}, 32'd1);
        check("basic_a_drained", {31'd0, a_valid}, 32'd0);
        drive(1'b0, 1'b0, '0);
        step();
        check("basic_b_drained", {31'd0, b_valid}, 32'd0);

        // backpressure isolation
        a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hC0);
        step();
        check("bp_a_load", {24'd0, a}, 32'hC0);
        drive(1'b1, 1'b0, 8'hD0);
        #1 check("bp_rdy_blocked", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_a_hold", {24'd0, a}, 32'hC0);
        check("bp_a_valid_hold", {31'd0, a_valid}, 32'd1);
        drive(1'b1, 1'b1, 8'hE0);
        #1 check("bp_rdy_other", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_b_load", {24'd0, b}, 32'hE0);
        check("bp_a_still", {24'd0, a}, 32'hC0);
        drive(1'b1, 1'b0, 8'hD0);
        a_ready = 1'b1;
        #1 check("bp_rdy_release", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_a_next", {24'd0, a}, 32'hD0);
        check("bp_a_next_valid", {31'd0, a_valid}, 32'd1);
        drive(1'b0, 1'b0, '0);
        step();
        check("bp_a_empty", {31'd0, a_valid}, 32'd0);

        // full throughput into b
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 1'b1, W'(i));
            #1 check("tp_rdy", {31'd0, in_ready}, 32'd1);
            step();
            check("tp_b", {24'd0, b}, i);
            check("tp_b_valid", {31'd0, b_valid}, 32'd1);
        end
        drive(1'b0, 1'b0, '0);
        step();
        check("tp_b_empty", {31'd0, b_valid}, 32'd0);
`ifdef DEMUX_XFER_CNT_EN
        check("tp_cnt_b", {28'd0, cnt_b}, exp_cnt_b % (1 << CW));
        check("tp_cnt_a", {28'd0, cnt_a}, exp_cnt_a % (1 << CW));
`endif

        // randomised traffic; source holds an unaccepted beat stable
        hold = 1'b0;
        for (int c = 0; c < 300; c++) begin
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 2) != 0);
            if (!hold) drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), W'($urandom));
            #1 acc = in_valid & in_ready;
            hold = in_valid & ~acc;
            step();
        end
        drive(1'b0, 1'b0, '0);
        a_ready = 1'b1; b_ready = 1'b1;
        step(); step();
        check("rand_qa_empty", qa.size(), 32'd0);
        check("rand_qb_empty", qb.size(), 32'd0);
`ifdef DEMUX_XFER_CNT_EN
        check("rand_cnt_a", {28'd0, cnt_a}, exp_cnt_a % (1 << CW));
        check("rand_cnt_b", {28'd0, cnt_b}, exp_cnt_b % (1 << CW));
`endif

        // asynchronous reset mid-operation
        a_ready = 1'b0;
        drive(1'b1, 1'b0, 8'hF0);
        step();
        drive(1'b0, 1'b0, '0);
        check("mid_a_load", {24'd0, a}, 32'hF0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("mid_rst_a", {24'd0, a}, 32'h00);
        step();
        rst_n = 1'b1;
        a_ready = 1'b1;
        step();
        check("post_rst_a_valid", {31'd0, a_valid}, 32'd0);
`ifdef DEMUX_XFER_CNT_EN
        check("post_rst_cnt_a", {28'd0, cnt_a}, 32'd0);
        check("post_rst_cnt_b", {28'd0, cnt_b}, 32'd0);

        // counter wrap: 17 transfers into a, one drain per cycle after the first
        for (int k = 1; k <= 17; k++) begin
            drive(1'b1, 1'b0, W'(k));
            step();
            if (k == 16) check("wrap_cnt_a_15", {28'd0, cnt_a}, 32'd15);
            if (k == 17) check("wrap_cnt_a_0", {28'd0, cnt_a}, 32'd0);
        end
        drive(1'b0, 1'b0, '0);
        step();
        check("wrap_cnt_a_1", {28'd0, cnt_a}, 32'd1);
        check("wrap_cnt_b_0", {28'd0, cnt_b}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
